// File: rtl/tl_memory.sv
// rtl/tl_memory.sv - MIPS MEM stage: data memory, sized load/store, branch resolve, MEM/WB register
// Optional feature macro: MEM_DEBUG_PORT_EN (combinational memory dump port for the debug unit)
module tl_memory #(
  parameter int LEN                  = 32,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 9,
  parameter int NB_ADDR_MEM          = 10
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [LEN-1:0]                  i_alu_result,
  input  logic [LEN-1:0]                  i_dato2,
  input  logic [LEN-1:0]                  i_add_execute,
  input  logic                            i_alu_zero,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  output logic                            o_pc_src,
  output logic [LEN-1:0]                  o_branch_target,
  output logic [LEN-1:0]                  o_rd_mem_corto,
  output logic [LEN-1:0]                  o_read_data,
  output logic [LEN-1:0]                  o_alu_result,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR_MEM-1:0]          i_debug_addr,
  output logic [LEN-1:0]                  o_debug_data
`endif
);

  localparam int MEM_WORDS = 1 << NB_ADDR_MEM;

  // Lane logic below assumes four byte lanes per word (LEN = 32).
  logic [LEN-1:0] mem [MEM_WORDS];

  logic                   mem_read;
  logic                   mem_write;
  logic                   branch_eq;
  logic                   branch_ne;
  logic [1:0]             acc_size;
  logic                   ld_unsigned;
  logic [NB_ADDR_MEM-1:0] word_idx;
  logic [1:0]             lane;

  assign mem_read    = i_ctrl_mem[8];
  assign mem_write   = i_ctrl_mem[7];
  assign branch_eq   = i_ctrl_mem[6];
  assign branch_ne   = i_ctrl_mem[5];
  assign acc_size    = i_ctrl_mem[4:3];
  assign ld_unsigned = i_ctrl_mem[2];
  assign word_idx    = i_alu_result[NB_ADDR_MEM+1:2];
  assign lane        = i_alu_result[1:0];

  // Reserved control bits and address bits above the memory size are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{i_ctrl_mem[1:0], i_alu_result[LEN-1:NB_ADDR_MEM+2]};

  assign o_pc_src        = (branch_eq & i_alu_zero) | (branch_ne & ~i_alu_zero);
  assign o_branch_target = i_add_execute;
  assign o_rd_mem_corto  = i_alu_result;

  logic [3:0]     byte_en;
  logic [LEN-1:0] wr_data;

  // Byte enables and replicated store data so every lane sees the right bytes.
  always_comb begin
    byte_en = 4'b1111;
    wr_data = i_dato2;
    case (acc_size)
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{i_dato2[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{i_dato2[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = i_dato2;
      end
    endcase
  end

  // Lane-masked store; contents survive reset, writes are held off while reset is low.
  always_ff @(negedge i_clk) begin
    if (i_rst && mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  logic [LEN-1:0] rd_word;
  logic [LEN-1:0] rd_shift;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [LEN-1:0] ld_value;

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};
  assign ld_byte  = rd_shift[7:0];
  assign ld_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // Lane select plus sign/zero extension; reads the pre-write word on a simultaneous store.
  always_comb begin
    ld_value = '0;
    if (mem_read) begin
      case (acc_size)
        2'b00:   ld_value = ld_unsigned ? {{(LEN-8){1'b0}}, ld_byte}
                                        : {{(LEN-8){ld_byte[7]}}, ld_byte};
        2'b01:   ld_value = ld_unsigned ? {{(LEN-16){1'b0}}, ld_half}
                                        : {{(LEN-16){ld_half[15]}}, ld_half};
        default: ld_value = rd_word;
      endcase
    end
  end

  // MEM/WB pipeline register, captured every negedge like the other stage registers.
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_write_reg  <= '0;
      o_ctrl_wb    <= '0;
    end else begin
      o_read_data  <= ld_value;
      o_alu_result <= i_alu_result;
      o_write_reg  <= i_write_reg;
      o_ctrl_wb    <= i_ctrl_wb;
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  assign o_debug_data = mem[i_debug_addr];
`endif

endmodule
